dram_stream_responder: RTL
==========================

DRAM_STREAM_RESPONDER -- requirements
Module: dram_stream_responder

Interface
REQ-001 Parameter DATA_W, default 16, width of one compressed data word.
REQ-002 Parameter IDX_W, default 4, width of one compressed-data index.
REQ-003 Parameter LEN_W, default 8, width of the element-count field.
REQ-004 Parameter ADDR_W, default 12, DRAM model word-address width.
REQ-005 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1, reset, asynchronous, active-low.
REQ-007 Port req_valid, input, 1, PE stream request present.
REQ-008 Port req_ready, output, 1, responder can accept a request.
REQ-009 Port req_kind, input, 1, request type: 0 = input activations (IARAM), 1 = filter weights.
REQ-010 Port req_base, input, ADDR_W, first DRAM word address.
REQ-011 Port req_len, input, LEN_W, number of compressed elements to stream.
REQ-012 Port mem_rd_en, output, 1, DRAM read strobe.
REQ-013 Port mem_rd_addr, output, ADDR_W, DRAM read address.
REQ-014 Port mem_rd_data, input, DATA_W+IDX_W, read return, {data, index}, valid exactly 1 cycle after mem_rd_en.
REQ-015 Port out_valid / out_ready, output / input, 1 / 1, element handshake toward the PE.
REQ-016 Port out_data / out_idx, output, DATA_W / IDX_W, streamed element and its index.
REQ-017 Port out_last, output, 1, marks the final element of a request.
REQ-018 Port stream_filter_finish / stream_input_finish, output, 1 / 1, completion pulses (Response_Stream_Complete).
REQ-019 Port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-020 The FSM SHALL have three states: IDLE, STREAM and DONE.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge with req_valid&&req_ready, latching kind, base and len.
REQ-022 On acceptance, the FSM SHALL go IDLE->STREAM if len>0, else IDLE->DONE.
REQ-023 In STREAM, the block SHALL read addresses base+k, k=0..len-1, in order, wrapping modulo 2^ADDR_W.
REQ-024 Read data SHALL land in a 2-entry FIFO; a read SHALL be issued only when occupancy plus in-flight reads < 2.
REQ-025 out_valid SHALL be high whenever the FIFO is non-empty; out_data/out_idx come from its head.
REQ-026 Output signals SHALL hold stable while out_valid && !out_ready.
REQ-027 Latency: the first mem_rd_en SHALL occur in the cycle after acceptance, and the first out_valid 2 cycles after acceptance.
REQ-028 With out_ready held high, throughput SHALL be one element per cycle with no bubbles.
REQ-029 out_last SHALL be high exactly with element len-1.
REQ-030 The out_last handshake SHALL move the FSM STREAM->DONE.
REQ-031 DONE SHALL last one cycle, pulse the finish matching the latched kind for exactly that cycle, then go to IDLE.
REQ-032 A zero-length request SHALL produce no reads and no out_valid, only the finish pulse.
REQ-033 req_valid while busy SHALL be ignored and not queued.
REQ-034 An FSM-driven FIFO flush: when a simultaneous push and pop occur at occupancy 2, occupancy SHALL stay 2 with order preserved.

Reset
REQ-035 Assertion of rst (low) SHALL immediately force IDLE, empty the FIFO, drop in-flight reads, and drive all outputs to 0 except req_ready=1.
REQ-036 Reset mid-stream SHALL NOT produce a finish pulse; late mem_rd_data after reset SHALL be ignored.

Configuration
REQ-037 Macro STREAM_CHECKSUM_EN, when defined, SHALL add an output stream_checksum[DATA_W-1:0] equal to the modulo-2^DATA_W sum of all out_data handshaked in the current request.
REQ-038 The checksum SHALL be cleared on acceptance and held valid in DONE and afterwards until the next acceptance.
REQ-039 Without STREAM_CHECKSUM_EN, the port and logic SHALL be absent and behaviour otherwise identical.

Verification
REQ-040 Input request: kind=0, base=0x010, len=4, out_ready=1 -> reads 0x010..0x013, out_valid high 4 consecutive cycles from acceptance+2, out_last on the 4th element, stream_input_finish pulsed once.
REQ-041 Filter request: kind=1, len=0 -> no mem_rd_en, no out_valid, stream_filter_finish pulsed in the cycle after acceptance.
REQ-042 Wrap and backpressure: base=0xFFE, len=3, out_ready toggling 1,0,0,1,... -> addresses 0xFFE, 0xFFF, 0x000; data held while stalled; never more than 2 reads outstanding.
REQ-043 Reset mid-stream: rst low after 2 of 5 elements -> outputs 0, req_ready=1, no finish; a following request streams correctly.
REQ-044 STREAM_CHECKSUM_EN: data 0x8000, 0x8001, 0x0005 -> stream_checksum=0x0006 in DONE.

Source files
------------

// File: rtl/dram_stream_responder_if.sv
// Request, DRAM-read and element-stream signals between a PE-side master and the responder.
interface dram_stream_responder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned ADDR_W = 12
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_kind;
  logic [ADDR_W-1:0]       req_base;
  logic [LEN_W-1:0]        req_len;
  logic                    mem_rd_en;
  logic [ADDR_W-1:0]       mem_rd_addr;
  logic [DATA_W+IDX_W-1:0] mem_rd_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [IDX_W-1:0]        out_idx;
  logic                    out_last;

  modport master (
    output req_valid, req_kind, req_base, req_len, out_ready, mem_rd_data,
    input  req_ready, mem_rd_en, mem_rd_addr, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  req_valid, req_kind, req_base, req_len, out_ready, mem_rd_data,
    output req_ready, mem_rd_en, mem_rd_addr, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/dram_stream_responder.sv
// Streams len compressed {data, index} words from DRAM to a PE through a 2-entry FIFO.
// Optional STREAM_CHECKSUM_EN adds a running modulo sum of handshaked data.
module dram_stream_responder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  dram_stream_responder_if.slave  bus,
  output logic                    busy,
  output logic                    stream_filter_finish,
  output logic                    stream_input_finish
`ifdef STREAM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]       stream_checksum
`endif
);

  localparam int unsigned WordW = DATA_W + IDX_W;

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e             state_q, state_d;
  logic               kind_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   rd_cnt_q;
  logic [LEN_W-1:0]   out_cnt_q;
  logic               inflight_q;
  logic [WordW-1:0]   fifo_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q;

  logic               accept, rd_en, fire, push, pop, head_valid;
  logic [1:0]         occupancy;
  logic [WordW-1:0]   head;

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    // Read data arriving this cycle counts as a slot; it bypasses the FIFO when empty.
    occupancy  = count_q + {1'b0, inflight_q};
    head_valid = (count_q != 2'd0) || inflight_q;
    head       = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : bus.mem_rd_data;
    rd_en      = (state_q == StStream) && (rd_cnt_q != len_q) && (occupancy < 2'd2);
    fire       = head_valid && bus.out_ready;
    push       = inflight_q && !((count_q == 2'd0) && fire);
    pop        = fire && (count_q != 2'd0);

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = (bus.req_len != '0) ? StStream : StDone;
        end
      end
      StStream: begin
        if (fire && (out_cnt_q == len_q - LEN_W'(1))) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    bus.req_ready        = (state_q == StIdle);
    bus.mem_rd_en        = rd_en;
    bus.mem_rd_addr      = rd_en ? rd_addr_q : '0;
    bus.out_valid        = head_valid;
    bus.out_data         = head_valid ? head[WordW-1:IDX_W] : '0;
    bus.out_idx          = head_valid ? head[IDX_W-1:0] : '0;
    bus.out_last         = head_valid && (out_cnt_q == len_q - LEN_W'(1));
    busy                 = (state_q != StIdle);
    stream_filter_finish = (state_q == StDone) && kind_q;
    stream_input_finish  = (state_q == StDone) && !kind_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      kind_q     <= 1'b0;
      rd_addr_q  <= '0;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      if (accept) begin
        kind_q    <= bus.req_kind;
        rd_addr_q <= bus.req_base;
        len_q     <= bus.req_len;
        rd_cnt_q  <= '0;
        out_cnt_q <= '0;
      end else begin
        if (rd_en) begin
          rd_addr_q <= rd_addr_q + ADDR_W'(1);
          rd_cnt_q  <= rd_cnt_q + LEN_W'(1);
        end
        if (fire) out_cnt_q <= out_cnt_q + LEN_W'(1);
      end
      // At full, a push writes the slot being popped, so order is preserved.
      if (push) begin
        fifo_q[wr_ptr_q] <= bus.mem_rd_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef STREAM_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= '0;
    end else if (fire) begin
      csum_q <= csum_q + head[WordW-1:IDX_W];
    end
  end

  assign stream_checksum = csum_q;
`endif

endmodule
